// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared vertex/triangle types and coordinate helpers for the triangle assembler
package render_pkg;

  localparam int VTX_W        = 136;
  localparam int AREA_W       = 35;
  localparam int COORD_W      = 16;
  localparam int BBOX_W       = 10;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  z;
    logic [31:0] u;
    logic [31:0] v;
  } vertex_t;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_SETUP,
    S_DECIDE,
    S_EMIT
  } tri_asm_state_t;

  // Integer pixel part of the Q16.16 screen coordinates.
  function automatic logic signed [COORD_W-1:0] vtx_xi(input vertex_t vtx);
    return vtx.x[31:16];
  endfunction

  function automatic logic signed [COORD_W-1:0] vtx_yi(input vertex_t vtx);
    return vtx.y[31:16];
  endfunction

  function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [BBOX_W-1:0] clamp_coord(input logic signed [COORD_W-1:0] c,
                                                    input logic signed [COORD_W-1:0] hi);
    logic signed [COORD_W-1:0] r;
    if (c[COORD_W-1])
      r = '0;
    else if (c > hi)
      r = hi;
    else
      r = c;
    return BBOX_W'(r);
  endfunction

endpackage

// File: rtl/tri_area_calc.sv
// rtl/tri_area_calc.sv - two-stage pipelined doubled signed triangle area
// Stage 1 registers the edge differences, stage 2 the cross-product difference.
module tri_area_calc
  import render_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic signed [COORD_W-1:0] i_x0,
  input  logic signed [COORD_W-1:0] i_y0,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  input  logic signed [COORD_W-1:0] i_x2,
  input  logic signed [COORD_W-1:0] i_y2,
  output logic signed [AREA_W-1:0]  o_area
);

  logic signed [COORD_W:0]     dx1, dy1, dx2, dy2;
  logic signed [2*COORD_W+1:0] p_a, p_b;

  assign p_a = dx1 * dy2;
  assign p_b = dx2 * dy1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dx1    <= '0;
      dy1    <= '0;
      dx2    <= '0;
      dy2    <= '0;
      o_area <= '0;
    end else begin
      dx1    <= $signed({i_x1[COORD_W-1], i_x1}) - $signed({i_x0[COORD_W-1], i_x0});
      dy1    <= $signed({i_y1[COORD_W-1], i_y1}) - $signed({i_y0[COORD_W-1], i_y0});
      dx2    <= $signed({i_x2[COORD_W-1], i_x2}) - $signed({i_x0[COORD_W-1], i_x0});
      dy2    <= $signed({i_y2[COORD_W-1], i_y2}) - $signed({i_y0[COORD_W-1], i_y0});
      o_area <= $signed({p_a[2*COORD_W+1], p_a}) - $signed({p_b[2*COORD_W+1], p_b});
    end
  end

endmodule

// File: rtl/triangle_assembler.sv
// rtl/triangle_assembler.sv - pops vertex triples, culls degenerate/off-screen triangles, emits to rasterizer
// Define BACKFACE_CULL_EN to also drop triangles with negative area.
module triangle_assembler
  import render_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_fifo_empty,
  output logic                     o_fifo_rd_en,
  input  logic [VTX_W-1:0]         i_fifo_data,
  input  logic                     i_flush,
  output logic                     o_tri_valid,
  input  logic                     i_tri_ready,
  output logic [VTX_W-1:0]         o_v0,
  output logic [VTX_W-1:0]         o_v1,
  output logic [VTX_W-1:0]         o_v2,
  output logic [BBOX_W-1:0]        o_bbox_xmin,
  output logic [BBOX_W-1:0]        o_bbox_xmax,
  output logic [BBOX_W-1:0]        o_bbox_ymin,
  output logic [BBOX_W-1:0]        o_bbox_ymax,
  output logic signed [AREA_W-1:0] o_area,
  output logic [15:0]              o_tri_count,
  output logic [15:0]              o_cull_count
);

  localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(SCREEN_H - 1);

  tri_asm_state_t            state;
  logic                      active;
  logic [1:0]                iss_cnt;
  logic [1:0]                rcv_cnt;
  logic                      rd_pending;
  logic                      setup_done;
  vertex_t                   slot [3];
  logic signed [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
  logic signed [COORD_W-1:0] xmin_raw, xmax_raw, ymin_raw, ymax_raw;
  logic signed [AREA_W-1:0]  area;
  logic                      degenerate, off_screen, backface, drop;

  assign x0 = vtx_xi(slot[0]);
  assign y0 = vtx_yi(slot[0]);
  assign x1 = vtx_xi(slot[1]);
  assign y1 = vtx_yi(slot[1]);
  assign x2 = vtx_xi(slot[2]);
  assign y2 = vtx_yi(slot[2]);

  tri_area_calc u_area (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_x0    (x0),
    .i_y0    (y0),
    .i_x1    (x1),
    .i_y1    (y1),
    .i_x2    (x2),
    .i_y2    (y2),
    .o_area  (area)
  );

  // Pop decision must see the current empty flag, so it stays combinational;
  // 'active' keeps it low while reset is asserted and on the first cycle after.
  assign o_fifo_rd_en = active && (state == S_COLLECT) && !i_fifo_empty
                        && (iss_cnt != 2'd3) && !i_flush;

  assign degenerate = (area == '0);
  assign off_screen = (xmin_raw > X_HI) || xmax_raw[COORD_W-1]
                   || (ymin_raw > Y_HI) || ymax_raw[COORD_W-1];
`ifdef BACKFACE_CULL_EN
  assign backface   = area[AREA_W-1];
`else
  assign backface   = 1'b0;
`endif
  assign drop       = degenerate || off_screen || backface;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_COLLECT;
      active       <= 1'b0;
      iss_cnt      <= '0;
      rcv_cnt      <= '0;
      rd_pending   <= 1'b0;
      setup_done   <= 1'b0;
      for (int i = 0; i < 3; i++) slot[i] <= '0;
      xmin_raw     <= '0;
      xmax_raw     <= '0;
      ymin_raw     <= '0;
      ymax_raw     <= '0;
      o_tri_valid  <= 1'b0;
      o_v0         <= '0;
      o_v1         <= '0;
      o_v2         <= '0;
      o_bbox_xmin  <= '0;
      o_bbox_xmax  <= '0;
      o_bbox_ymin  <= '0;
      o_bbox_ymax  <= '0;
      o_area       <= '0;
      o_tri_count  <= '0;
      o_cull_count <= '0;
    end else begin
      active     <= 1'b1;
      rd_pending <= o_fifo_rd_en;
      case (state)
        S_COLLECT: begin
          // A flush also drops the data of a pop issued on the previous cycle.
          if (i_flush) begin
            iss_cnt <= '0;
            rcv_cnt <= '0;
          end else begin
            if (o_fifo_rd_en) iss_cnt <= iss_cnt + 2'd1;
            if (rd_pending) begin
              slot[rcv_cnt] <= i_fifo_data;
              if (rcv_cnt == 2'd2) begin
                rcv_cnt    <= '0;
                iss_cnt    <= '0;
                setup_done <= 1'b0;
                state      <= S_SETUP;
              end else begin
                rcv_cnt <= rcv_cnt + 2'd1;
              end
            end
          end
        end
        S_SETUP: begin
          if (!setup_done) begin
            xmin_raw   <= min3(x0, x1, x2);
            xmax_raw   <= max3(x0, x1, x2);
            ymin_raw   <= min3(y0, y1, y2);
            ymax_raw   <= max3(y0, y1, y2);
            setup_done <= 1'b1;
          end else begin
            setup_done <= 1'b0;
            state      <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (drop) begin
            o_cull_count <= o_cull_count + 16'd1;
            state        <= S_COLLECT;
          end else begin
            o_v0        <= slot[0];
            o_v1        <= slot[1];
            o_v2        <= slot[2];
            o_bbox_xmin <= clamp_coord(xmin_raw, X_HI);
            o_bbox_xmax <= clamp_coord(xmax_raw, X_HI);
            o_bbox_ymin <= clamp_coord(ymin_raw, Y_HI);
            o_bbox_ymax <= clamp_coord(ymax_raw, Y_HI);
            o_area      <= area;
            o_tri_valid <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_tri_ready) begin
            o_tri_valid <= 1'b0;
            o_tri_count <= o_tri_count + 16'd1;
            state       <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// tb/tb_triangle_assembler.sv - model-checked directed bench for triangle_assembler
module tb_triangle_assembler;
  import render_pkg::*;

  localparam int SW = 320;
  localparam int SH = 240;
  localparam int OW = 3 * VTX_W + 4 * BBOX_W + AREA_W + 32;
`ifdef BACKFACE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               fifo_empty;
  logic               rd_en;
  logic [VTX_W-1:0]   fifo_data;
  logic               flush;
  logic               tri_valid;
  logic               tri_ready;
  logic [VTX_W-1:0]   v0, v1, v2;
  logic [BBOX_W-1:0]  bxmin, bxmax, bymin, bymax;
  logic [AREA_W-1:0]  area;
  logic [15:0]        tri_count, cull_count;

  triangle_assembler #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (rd_en),
    .i_fifo_data  (fifo_data),
    .i_flush      (flush),
    .o_tri_valid  (tri_valid),
    .i_tri_ready  (tri_ready),
    .o_v0         (v0),
    .o_v1         (v1),
    .o_v2         (v2),
    .o_bbox_xmin  (bxmin),
    .o_bbox_xmax  (bxmax),
    .o_bbox_ymin  (bymin),
    .o_bbox_ymax  (bymax),
    .o_area       (area),
    .o_tri_count  (tri_count),
    .o_cull_count (cull_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VTX_W-1:0] v0, v1, v2;
    int               bx0, bx1, by0, by1;
    longint           area;
  } exp_t;

  exp_t             exp_q[$];
  logic [VTX_W-1:0] fifo_q[$];
  int n_checks = 0, n_errors = 0;
  int model_cull = 0, model_emitted = 0, n_hs = 0;
  int cyc = 0, last_data_cyc = 0, valid_rise_cyc = 0, pop_cnt = 0;
  bit pop_flag = 1'b0, ready_req = 1'b1, flush_req = 1'b0;
  bit prev_valid = 1'b0, prev_hold = 1'b0;
  logic [OW-1:0]    held;
  longint           last_area = 0;
  logic [VTX_W-1:0] last_v0 = '0;
  int last_bx0 = 0, last_bx1 = 0, last_by0 = 0, last_by1 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] snap();
    return {v0, v1, v2, bxmin, bxmax, bymin, bymax, area, tri_count, cull_count};
  endfunction

  function automatic logic [VTX_W-1:0] mkv(input int xi, input int yi, input int tag);
    return {16'(xi), 16'h4000, 16'(yi), 16'hC000, 8'(tag), 32'(tag * 3 + 1), 32'(tag * 7 + 2)};
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int min3i(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int max3i(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Model: what the rasterizer must receive for one vertex triple.
  task automatic push_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input int tag);
    exp_t e;
    int mnx, mxx, mny, mxy;
    e.v0 = mkv(ax, ay, tag);
    e.v1 = mkv(bx, by, tag + 1);
    e.v2 = mkv(cx, cy, tag + 2);
    fifo_q.push_back(e.v0);
    fifo_q.push_back(e.v1);
    fifo_q.push_back(e.v2);
    e.area = longint'(bx - ax) * longint'(cy - ay) - longint'(cx - ax) * longint'(by - ay);
    mnx = min3i(ax, bx, cx);
    mxx = max3i(ax, bx, cx);
    mny = min3i(ay, by, cy);
    mxy = max3i(ay, by, cy);
    if (e.area == 0 || mnx > SW - 1 || mxx < 0 || mny > SH - 1 || mxy < 0 || (CULL && e.area < 0)) begin
      model_cull++;
    end else begin
      e.bx0 = clampi(mnx, SW - 1);
      e.bx1 = clampi(mxx, SW - 1);
      e.by0 = clampi(mny, SH - 1);
      e.by1 = clampi(mxy, SH - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: FIFO delivers last cycle's pop, inputs change at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pop_flag) begin
      fifo_data = fifo_q.pop_front();
      last_data_cyc = cyc;
    end
    fifo_empty = (fifo_q.size() == 0);
    flush      = flush_req;
    tri_ready  = ready_req;
    #1;
    pop_flag = rd_en;
    if (pop_flag) pop_cnt++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || pop_flag) && n < 300) begin
      step();
      n++;
    end
    if (fifo_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: fifo holds %0d vertices, required 0", fifo_q.size());
    end
    repeat (12) step();
    chk("pending_triangles", exp_q.size(), 0);
    chk("cull_count", cull_count, model_cull);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_vec(name, snap(), '0);
    chk({name, "_valid"}, tri_valid, 0);
    chk({name, "_rd_en"}, rd_en, 0);
  endtask

  // Compare process: outputs are settled and the next edge's inputs are driven.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (tri_valid) begin
        chk("rd_en_while_valid", rd_en, 0);
        if (prev_hold) chk_vec("hold_stable", snap(), held);
        if (!prev_valid) valid_rise_cyc = cyc;
        if (tri_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_triangle: got area %0d, expected no triangle", $signed(area));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("area", longint'($signed(area)), e.area);
            chk("bbox_xmin", bxmin, e.bx0);
            chk("bbox_xmax", bxmax, e.bx1);
            chk("bbox_ymin", bymin, e.by0);
            chk("bbox_ymax", bymax, e.by1);
            chk_vec("vertices", {v0, v1, v2}, {e.v0, e.v1, e.v2});
            chk("tri_count", tri_count, model_emitted);
          end
          model_emitted++;
          n_hs++;
          last_area = longint'($signed(area));
          last_v0   = v0;
          last_bx0  = bxmin;
          last_bx1  = bxmax;
          last_by0  = bymin;
          last_by1  = bymax;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          held      = snap();
        end
      end else begin
        prev_hold = 1'b0;
      end
      prev_valid = tri_valid;
    end
  end

  initial begin
    int hs0, base, n;
    rst_n      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    flush      = 1'b0;
    tri_ready  = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset_state");
    rst_n = 1'b1;

    // Counter-clockwise triangle fully on screen
    push_tri(10, 10, 50, 10, 10, 40, 1);
    drain();
    chk("t1_area", last_area, 1200);
    chk("t1_xmin", last_bx0, 10);
    chk("t1_xmax", last_bx1, 50);
    chk("t1_ymin", last_by0, 10);
    chk("t1_ymax", last_by1, 40);
    chk("t1_tri_count", tri_count, 1);
    chk("t1_latency", valid_rise_cyc - last_data_cyc, 4);

    // Clockwise winding
    push_tri(10, 10, 10, 40, 50, 10, 4);
    drain();
`ifdef BACKFACE_CULL_EN
    chk("t2_cull_count", cull_count, 1);
    chk("t2_tri_count", tri_count, 1);
`else
    chk("t2_area", last_area, -1200);
    chk("t2_cull_count", cull_count, 0);
`endif

    // Collinear vertices
    hs0 = n_hs;
    push_tri(0, 0, 10, 10, 20, 20, 7);
    drain();
    chk("t3_no_valid", n_hs, hs0);

    // Partially off-screen (clamped) and fully off-screen
    push_tri(-20, 5, 30, 5, -20, 60, 10);
    drain();
    chk("t4_area", last_area, 2750);
    chk("t4_xmin", last_bx0, 0);
    chk("t4_xmax", last_bx1, 30);
    chk("t4_ymax", last_by1, 60);
    push_tri(400, 0, 410, 0, 400, 10, 13);
    drain();
`ifdef BACKFACE_CULL_EN
    chk("t4_cull_count", cull_count, 3);
`else
    chk("t4_cull_count", cull_count, 2);
`endif

    // Flush on the cycle the second pop's data arrives
    fifo_q.push_back(mkv(1, 1, 20));
    fifo_q.push_back(mkv(2, 2, 21));
    base = pop_cnt;
    n = 0;
    while (pop_cnt < base + 2 && n < 50) begin
      step();
      n++;
    end
    chk("t5_pops_before_flush", pop_cnt - base, 2);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    push_tri(5, 5, 100, 5, 5, 80, 22);
    drain();
    chk("t5_area", last_area, 7125);
    chk_vec("t5_v0", OW'(last_v0), OW'(mkv(5, 5, 22)));

    // Backpressure with a non-empty FIFO, then reset while emitting
    ready_req = 1'b0;
    push_tri(10, 10, 50, 10, 10, 40, 30);
    push_tri(20, 20, 60, 20, 20, 70, 33);
    n = 0;
    while (!tri_valid && n < 60) begin
      step();
      n++;
    end
    chk("t6_valid_seen", tri_valid, 1);
    repeat (5) step();
    chk("t6_fifo_untouched", fifo_q.size(), 3);
    chk("t6_valid_held", tri_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_reset_mid_emit");
    fifo_q.delete();
    exp_q.delete();
    model_cull    = 0;
    model_emitted = 0;
    repeat (2) step();
    pop_flag  = 1'b0;
    rst_n     = 1'b1;
    ready_req = 1'b1;
    push_tri(10, 10, 50, 10, 10, 40, 40);
    drain();
    chk("t6_recover_count", tri_count, 1);
    chk("t6_recover_area", last_area, 1200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
